// File: rtl/audio_output_buffer_pkg.sv
// Shared audio definitions: sample width, stereo sample layout and the
// output-buffer state encodings, reused by later audio blocks.
package audio_output_buffer_pkg;

    localparam int unsigned AUDIO_SAMPLE_WIDTH = 16;

    typedef enum logic {
        AOB_STATE_PRIME = 1'b0,
        AOB_STATE_RUN   = 1'b1
    } aob_state_e;

    typedef struct packed {
        logic [AUDIO_SAMPLE_WIDTH-1:0] l;
        logic [AUDIO_SAMPLE_WIDTH-1:0] r;
    } stereo_sample_t;

endpackage

// File: rtl/audio_output_buffer_if.sv
// Sample, status and flag-clear signals between the mixer/DAC side and the
// output buffer; the buffer itself takes the slave view.
interface audio_output_buffer_if #(
    parameter int unsigned DEPTH_LOG2 = 3
);
    import audio_output_buffer_pkg::*;

    logic                          audio_in_valid;
    logic [AUDIO_SAMPLE_WIDTH-1:0] audio_in_l;
    logic [AUDIO_SAMPLE_WIDTH-1:0] audio_in_r;
    logic [AUDIO_SAMPLE_WIDTH-1:0] audio_out_l;
    logic [AUDIO_SAMPLE_WIDTH-1:0] audio_out_r;
    logic                          audio_out_valid;
    logic [DEPTH_LOG2:0]           fifo_level;
    logic                          overflow;
    logic                          underrun;
    logic                          flags_clear;

    modport master (
        output audio_in_valid, audio_in_l, audio_in_r, flags_clear,
        input  audio_out_l, audio_out_r, audio_out_valid, fifo_level,
               overflow, underrun
    );

    modport slave (
        input  audio_in_valid, audio_in_l, audio_in_r, flags_clear,
        output audio_out_l, audio_out_r, audio_out_valid, fifo_level,
               overflow, underrun
    );

endinterface

// File: rtl/audio_output_buffer_sample_rate_tick.sv
// Fractional-accumulator rate generator: emits a registered one-cycle tick
// at exactly RATE per second from a CLK_FREQ clock, with no long-run drift.
module sample_rate_tick #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned RATE     = 44100
) (
    input  logic clk_2x,
    input  logic reset_n,
    output logic tick
);

    logic [31:0] acc_q, acc_d;
    logic [32:0] sum;
    logic        tick_q, tick_d;

    // The extra sum bit keeps the compare exact when CLK_FREQ is near 2^32.
    always_comb begin
        sum    = {1'b0, acc_q} + 33'(RATE);
        acc_d  = sum[31:0];
        tick_d = 1'b0;
        if (sum >= 33'(CLK_FREQ)) begin
            acc_d  = 32'(sum - 33'(CLK_FREQ));
            tick_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk_2x or negedge reset_n) begin
        if (!reset_n) begin
            acc_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/audio_output_buffer.sv
// Elastic stereo FIFO that releases samples at a fixed rate; it primes to
// half-full before playing and drops back to priming when it runs dry.
module audio_output_buffer
    import audio_output_buffer_pkg::*;
#(
    parameter int unsigned CLK_2X_FREQ = 50_000_000,
    parameter int unsigned SAMPLE_RATE = 44100,
    parameter int unsigned DEPTH_LOG2  = 3
) (
    input  logic                 clk_2x,
    input  logic                 reset_n,
    audio_output_buffer_if.slave bus
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
    localparam logic [PTR_W-1:0] PRIME_THRESHOLD = PTR_W'(DEPTH / 2);

    logic tick;

    sample_rate_tick #(
        .CLK_FREQ (CLK_2X_FREQ),
        .RATE     (SAMPLE_RATE)
    ) u_tick (
        .clk_2x  (clk_2x),
        .reset_n (reset_n),
        .tick    (tick)
    );

    stereo_sample_t        mem_q [DEPTH];
    stereo_sample_t        in_sample;
    stereo_sample_t        out_q, out_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level;
    logic [DEPTH_LOG2-1:0] wr_idx, rd_idx;
    logic                  empty, full, push, pop, drop, underrun_set;
    logic                  out_valid_q, out_valid_d;
    logic                  overflow_q, overflow_d, underrun_q, underrun_d;
    aob_state_e            state_q, state_d;

    assign in_sample = {bus.audio_in_l, bus.audio_in_r};
    assign wr_idx    = wr_ptr_q[DEPTH_LOG2-1:0];
    assign rd_idx    = rd_ptr_q[DEPTH_LOG2-1:0];
    assign level     = wr_ptr_q - rd_ptr_q;
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) && (wr_idx == rd_idx);

    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        underrun_set = 1'b0;
        case (state_q)
            AOB_STATE_PRIME: begin
                if (level >= PRIME_THRESHOLD) state_d = AOB_STATE_RUN;
            end
            AOB_STATE_RUN: begin
                if (tick) begin
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        underrun_set = 1'b1;
                        state_d      = AOB_STATE_PRIME;
                    end
                end
            end
            default: state_d = AOB_STATE_PRIME;
        endcase
    end

    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    always_comb begin
        push        = bus.audio_in_valid && (!full || pop);
        drop        = bus.audio_in_valid && full && !pop;
        wr_ptr_d    = wr_ptr_q + PTR_W'(push);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        out_d       = pop ? mem_q[rd_idx] : out_q;
        out_valid_d = tick;
        overflow_d  = bus.flags_clear ? 1'b0 : (overflow_q | drop);
        underrun_d  = bus.flags_clear ? 1'b0 : (underrun_q | underrun_set);
    end

    always_ff @(posedge clk_2x or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= AOB_STATE_PRIME;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            underrun_q  <= underrun_d;
        end
    end

    // NOTE: the storage array has no reset; clearing the pointers already
    // discards its contents, and leaving it unreset keeps it a plain RAM.
    always_ff @(posedge clk_2x) begin
        if (push) mem_q[wr_idx] <= in_sample;
    end

    assign bus.audio_out_l     = out_q.l;
    assign bus.audio_out_r     = out_q.r;
    assign bus.audio_out_valid = out_valid_q;
    assign bus.fifo_level      = level;
    assign bus.overflow        = overflow_q;
    assign bus.underrun        = underrun_q;

endmodule

// File: tb/tb_audio_output_buffer.sv
// Scoreboard bench for audio_output_buffer: a tick every 10 cycles, 4-entry
// FIFO; accepted pushes are queued and compared when the DUT pops them.
module tb_audio_output_buffer;

    logic clk_2x  = 1'b0;
    logic reset_n = 1'b0;
    int   edge_cnt;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [31:0] exp_q [$];

    audio_output_buffer_if #(.DEPTH_LOG2(2)) bus ();

    audio_output_buffer #(
        .CLK_2X_FREQ (441000),
        .SAMPLE_RATE (44100),
        .DEPTH_LOG2  (2)
    ) dut (
        .clk_2x  (clk_2x),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk_2x = ~clk_2x;

    // Edge 0 is the first rising edge after reset release.
    always @(posedge clk_2x or negedge reset_n) begin
        if (!reset_n) edge_cnt <= -1;
        else          edge_cnt <= edge_cnt + 1;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish within 1 ms");
        $fatal(1);
    end

    task automatic apply_reset();
        bus.audio_in_valid = 1'b0;
        bus.audio_in_l     = '0;
        bus.audio_in_r     = '0;
        bus.flags_clear    = 1'b0;
        exp_q.delete();
        @(negedge clk_2x);
        reset_n = 1'b0;
        repeat (3) @(negedge clk_2x);
        reset_n = 1'b1;
    endtask

    // Drives one push for the next rising edge; returns at the following negedge.
    task automatic push_sample(input logic [15:0] l, input logic [15:0] r, input bit accept);
        bus.audio_in_l     = l;
        bus.audio_in_r     = r;
        bus.audio_in_valid = 1'b1;
        if (accept) exp_q.push_back({l, r});
        @(negedge clk_2x);
        bus.audio_in_valid = 1'b0;
    endtask

    task automatic wait_pulse(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_2x);
            if (bus.audio_out_valid) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_edge(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (edge_cnt == target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_2x);
        end
    endtask

    task automatic next_expected(output logic [31:0] e);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = 'x;
    endtask

    task automatic test_reset();
        bus.audio_in_valid = 1'b0;
        bus.audio_in_l     = '0;
        bus.audio_in_r     = '0;
        bus.flags_clear    = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk_2x);
        n_checks++; if (bus.audio_out_l !== 16'h0) begin n_errors++; $display("FAIL reset_out_l: got %h want 0000", bus.audio_out_l); end
        n_checks++; if (bus.audio_out_r !== 16'h0) begin n_errors++; $display("FAIL reset_out_r: got %h want 0000", bus.audio_out_r); end
        n_checks++; if (bus.audio_out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", bus.audio_out_valid); end
        n_checks++; if (bus.fifo_level !== 3'd0) begin n_errors++; $display("FAIL reset_level: got %0d want 0", bus.fifo_level); end
        n_checks++; if (bus.overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
        n_checks++; if (bus.underrun !== 1'b0) begin n_errors++; $display("FAIL reset_underrun: got %b want 0", bus.underrun); end
        reset_n = 1'b1;
    endtask

    task automatic test_cadence();
        int pulses = 0, first = -1, misplaced = 0, out_nz = 0, level_nz = 0;
        apply_reset();
        for (int i = 0; i <= 1000; i++) begin
            @(negedge clk_2x);
            if (bus.audio_out_valid === 1'b1) begin
                pulses++;
                if (first < 0) first = edge_cnt;
                if (edge_cnt == 0 || (edge_cnt % 10) != 0) misplaced++;
            end
            if (bus.audio_out_l !== 16'h0 || bus.audio_out_r !== 16'h0) out_nz++;
            if (bus.fifo_level !== 3'd0) level_nz++;
        end
        n_checks++; if (pulses != 100) begin n_errors++; $display("FAIL cadence_count: got %0d pulses want 100", pulses); end
        n_checks++; if (first != 10) begin n_errors++; $display("FAIL cadence_first: got cycle %0d want 10", first); end
        n_checks++; if (misplaced != 0) begin n_errors++; $display("FAIL cadence_spacing: %0d pulses off the 10-cycle grid, want 0", misplaced); end
        n_checks++; if (out_nz != 0) begin n_errors++; $display("FAIL cadence_outputs: %0d cycles with nonzero output, want 0", out_nz); end
        n_checks++; if (level_nz != 0) begin n_errors++; $display("FAIL cadence_level: %0d cycles with nonzero level, want 0", level_nz); end
        n_checks++; if (bus.underrun !== 1'b0) begin n_errors++; $display("FAIL cadence_underrun: got %b want 0", bus.underrun); end
    endtask

    task automatic test_prime_run();
        bit seen;
        logic [31:0] e;
        apply_reset();
        push_sample(16'h1111, 16'hAAAA, 1'b1);
        push_sample(16'h2222, 16'hBBBB, 1'b1);
        n_checks++; if (bus.fifo_level !== 3'd2) begin n_errors++; $display("FAIL prime_level: got %0d want 2", bus.fifo_level); end
        for (int i = 0; i < 4; i++) begin
            wait_pulse(20, seen);
            n_checks++; if (!seen) begin n_errors++; $display("FAIL prime_run_pulse%0d: no output pulse within 20 cycles", i); end
            next_expected(e);
            n_checks++; if ({bus.audio_out_l, bus.audio_out_r} !== e) begin n_errors++; $display("FAIL prime_run_sample%0d: got %h want %h", i, {bus.audio_out_l, bus.audio_out_r}, e); end
            push_sample(16'h3000 + 16'(i), 16'hC000 + 16'(i), 1'b1);
        end
        n_checks++; if (bus.underrun !== 1'b0) begin n_errors++; $display("FAIL prime_run_underrun: got %b want 0", bus.underrun); end
    endtask

    task automatic test_overflow();
        bit seen;
        logic [31:0] e;
        apply_reset();
        for (int k = 0; k < 6; k++) push_sample(16'h0100 + 16'(k), 16'hF100 + 16'(k), k < 4);
        n_checks++; if (bus.fifo_level !== 3'd4) begin n_errors++; $display("FAIL overflow_level: got %0d want 4", bus.fifo_level); end
        n_checks++; if (bus.overflow !== 1'b1) begin n_errors++; $display("FAIL overflow_flag: got %b want 1", bus.overflow); end
        for (int i = 0; i < 4; i++) begin
            wait_pulse(20, seen);
            n_checks++; if (!seen) begin n_errors++; $display("FAIL overflow_pulse%0d: no output pulse within 20 cycles", i); end
            next_expected(e);
            n_checks++; if ({bus.audio_out_l, bus.audio_out_r} !== e) begin n_errors++; $display("FAIL overflow_sample%0d: got %h want %h", i, {bus.audio_out_l, bus.audio_out_r}, e); end
        end
        wait_pulse(20, seen);
        n_checks++; if (!seen) begin n_errors++; $display("FAIL overflow_drain_pulse: no output pulse within 20 cycles"); end
        n_checks++; if ({bus.audio_out_l, bus.audio_out_r} !== 32'h0103_F103) begin n_errors++; $display("FAIL overflow_dropped_hidden: got %h want 0103f103", {bus.audio_out_l, bus.audio_out_r}); end
        n_checks++; if (bus.underrun !== 1'b1) begin n_errors++; $display("FAIL overflow_drain_underrun: got %b want 1", bus.underrun); end
        bus.flags_clear = 1'b1;
        @(negedge clk_2x);
        bus.flags_clear = 1'b0;
        n_checks++; if (bus.overflow !== 1'b0) begin n_errors++; $display("FAIL overflow_clear: got %b want 0", bus.overflow); end
    endtask

    task automatic test_underrun();
        bit seen, ok;
        logic [31:0] e;
        apply_reset();
        push_sample(16'h5001, 16'hA001, 1'b1);
        push_sample(16'h5002, 16'hA002, 1'b1);
        for (int i = 0; i < 2; i++) begin
            wait_pulse(20, seen);
            next_expected(e);
            n_checks++; if ({bus.audio_out_l, bus.audio_out_r} !== e) begin n_errors++; $display("FAIL underrun_drain%0d: got %h want %h", i, {bus.audio_out_l, bus.audio_out_r}, e); end
        end
        wait_pulse(20, seen);
        n_checks++; if ({bus.audio_out_l, bus.audio_out_r} !== 32'h5002_A002) begin n_errors++; $display("FAIL underrun_hold: got %h want 5002a002", {bus.audio_out_l, bus.audio_out_r}); end
        n_checks++; if (bus.underrun !== 1'b1) begin n_errors++; $display("FAIL underrun_flag: got %b want 1", bus.underrun); end
        push_sample(16'h6001, 16'hB001, 1'b1);
        push_sample(16'h6002, 16'hB002, 1'b1);
        for (int i = 0; i < 2; i++) begin
            wait_pulse(20, seen);
            n_checks++; if (!seen) begin n_errors++; $display("FAIL underrun_resume_pulse%0d: no output pulse within 20 cycles", i); end
            next_expected(e);
            n_checks++; if ({bus.audio_out_l, bus.audio_out_r} !== e) begin n_errors++; $display("FAIL underrun_resume%0d: got %h want %h", i, {bus.audio_out_l, bus.audio_out_r}, e); end
        end
        n_checks++; if (bus.underrun !== 1'b1) begin n_errors++; $display("FAIL underrun_sticky: got %b want 1", bus.underrun); end
        bus.flags_clear = 1'b1;
        @(negedge clk_2x);
        bus.flags_clear = 1'b0;
        n_checks++; if (bus.underrun !== 1'b0) begin n_errors++; $display("FAIL underrun_clear: got %b want 0", bus.underrun); end
        // Clear on the very tick that finds the FIFO empty again.
        wait_edge(59, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL underrun_wait_edge59: reached cycle %0d", edge_cnt); end
        bus.flags_clear = 1'b1;
        @(negedge clk_2x);
        bus.flags_clear = 1'b0;
        n_checks++; if (bus.audio_out_valid !== 1'b1) begin n_errors++; $display("FAIL clear_priority_pulse: got %b want 1", bus.audio_out_valid); end
        n_checks++; if (bus.underrun !== 1'b0) begin n_errors++; $display("FAIL clear_priority: got %b want 0", bus.underrun); end
    endtask

    task automatic test_simultaneous();
        bit seen, ok;
        logic [31:0] e;
        apply_reset();
        for (int k = 0; k < 4; k++) push_sample(16'h7000 + 16'(k), 16'hD000 + 16'(k), 1'b1);
        wait_edge(9, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL simul_wait_edge9: reached cycle %0d", edge_cnt); end
        push_sample(16'h7004, 16'hD004, 1'b1);
        n_checks++; if (bus.audio_out_valid !== 1'b1) begin n_errors++; $display("FAIL simul_full_pulse: got %b want 1", bus.audio_out_valid); end
        n_checks++; if (bus.fifo_level !== 3'd4) begin n_errors++; $display("FAIL simul_full_level: got %0d want 4", bus.fifo_level); end
        n_checks++; if (bus.overflow !== 1'b0) begin n_errors++; $display("FAIL simul_full_overflow: got %b want 0", bus.overflow); end
        next_expected(e);
        n_checks++; if ({bus.audio_out_l, bus.audio_out_r} !== e) begin n_errors++; $display("FAIL simul_full_sample0: got %h want %h", {bus.audio_out_l, bus.audio_out_r}, e); end
        for (int i = 1; i < 5; i++) begin
            wait_pulse(20, seen);
            next_expected(e);
            n_checks++; if ({bus.audio_out_l, bus.audio_out_r} !== e) begin n_errors++; $display("FAIL simul_full_sample%0d: got %h want %h", i, {bus.audio_out_l, bus.audio_out_r}, e); end
        end

        apply_reset();
        push_sample(16'h8001, 16'hE001, 1'b1);
        push_sample(16'h8002, 16'hE002, 1'b1);
        for (int i = 0; i < 2; i++) begin
            wait_pulse(20, seen);
            next_expected(e);
            n_checks++; if ({bus.audio_out_l, bus.audio_out_r} !== e) begin n_errors++; $display("FAIL simul_empty_drain%0d: got %h want %h", i, {bus.audio_out_l, bus.audio_out_r}, e); end
        end
        wait_edge(29, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL simul_wait_edge29: reached cycle %0d", edge_cnt); end
        push_sample(16'h8003, 16'hE003, 1'b1);
        n_checks++; if (bus.underrun !== 1'b1) begin n_errors++; $display("FAIL simul_empty_underrun: got %b want 1", bus.underrun); end
        n_checks++; if ({bus.audio_out_l, bus.audio_out_r} !== 32'h8002_E002) begin n_errors++; $display("FAIL simul_empty_hold: got %h want 8002e002", {bus.audio_out_l, bus.audio_out_r}); end
        n_checks++; if (bus.fifo_level !== 3'd1) begin n_errors++; $display("FAIL simul_empty_level: got %0d want 1", bus.fifo_level); end
        wait_pulse(20, seen);
        n_checks++; if ({bus.audio_out_l, bus.audio_out_r} !== 32'h8002_E002) begin n_errors++; $display("FAIL simul_reprime_hold: got %h want 8002e002", {bus.audio_out_l, bus.audio_out_r}); end
        push_sample(16'h8004, 16'hE004, 1'b1);
        for (int i = 0; i < 2; i++) begin
            wait_pulse(20, seen);
            next_expected(e);
            n_checks++; if ({bus.audio_out_l, bus.audio_out_r} !== e) begin n_errors++; $display("FAIL simul_reprime_sample%0d: got %h want %h", i, {bus.audio_out_l, bus.audio_out_r}, e); end
        end
    endtask

    task automatic test_async_reset();
        bit seen;
        logic [31:0] e;
        apply_reset();
        for (int k = 0; k < 3; k++) push_sample(16'h9000 + 16'(k), 16'h4000 + 16'(k), 1'b1);
        wait_pulse(20, seen);
        next_expected(e);
        n_checks++; if ({bus.audio_out_l, bus.audio_out_r} !== e) begin n_errors++; $display("FAIL async_pre_sample: got %h want %h", {bus.audio_out_l, bus.audio_out_r}, e); end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if ({bus.audio_out_l, bus.audio_out_r} !== 32'h0) begin n_errors++; $display("FAIL async_out: got %h want 00000000", {bus.audio_out_l, bus.audio_out_r}); end
        n_checks++; if (bus.audio_out_valid !== 1'b0) begin n_errors++; $display("FAIL async_valid: got %b want 0", bus.audio_out_valid); end
        n_checks++; if (bus.fifo_level !== 3'd0) begin n_errors++; $display("FAIL async_level: got %0d want 0", bus.fifo_level); end
        exp_q.delete();
        repeat (3) @(negedge clk_2x);
        reset_n = 1'b1;
        wait_pulse(20, seen);
        n_checks++; if (!seen || edge_cnt != 10) begin n_errors++; $display("FAIL async_first_pulse: seen=%b at cycle %0d want cycle 10", seen, edge_cnt); end
        n_checks++; if ({bus.audio_out_l, bus.audio_out_r} !== 32'h0) begin n_errors++; $display("FAIL async_discarded: got %h want 00000000", {bus.audio_out_l, bus.audio_out_r}); end
    endtask

    initial begin
        test_reset();
        test_cadence();
        test_prime_run();
        test_overflow();
        test_underrun();
        test_simultaneous();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
